// File: rtl/tap_pkg.sv
// Shared TAP types and constants: state encoding, default opcodes, IR capture pattern.
package tap_pkg;

  localparam int unsigned TAP_IR_W = 4;

  localparam logic [3:0] TAP_IDCODE_OP = 4'b0001;
  localparam logic [3:0] TAP_BYPASS_OP = 4'b1111;

  // Low two bits loaded into the IR shift register in CAP_IR; upper bits are zero.
  localparam logic [1:0] TAP_IR_CAPTURE = 2'b01;

  // Standard 1149.1 state encoding.
  typedef enum logic [3:0] {
    TLR      = 4'hF,
    RTI      = 4'hC,
    SEL_DR   = 4'h7,
    CAP_DR   = 4'h6,
    SHIFT_DR = 4'h2,
    EXIT1_DR = 4'h1,
    PAUSE_DR = 4'h3,
    EXIT2_DR = 4'h0,
    UPD_DR   = 4'h5,
    SEL_IR   = 4'h4,
    CAP_IR   = 4'hE,
    SHIFT_IR = 4'hA,
    EXIT1_IR = 4'h9,
    PAUSE_IR = 4'hB,
    EXIT2_IR = 4'h8,
    UPD_IR   = 4'hD
  } tap_state_t;

endpackage

// File: rtl/tap_if.sv
// TAP pin/strobe bundle between the controller (master) and its user (slave).
interface tap_if
  import tap_pkg::*;
#(
  parameter int unsigned IR_W = TAP_IR_W
);

  logic            TMS;
  logic            TDI;
  logic            idr_tdo;
  logic            byp_tdo;
  logic            TDO;
  logic            tdo_en;
  logic            CaptureDR;
  logic            ShiftDR;
  logic            UpdateDR;
  logic            sel_idr;
  logic            sel_byp;
  logic [IR_W-1:0] ir;
  logic [3:0]      tap_state;

  modport master (
    input  TMS, TDI, idr_tdo, byp_tdo,
    output TDO, tdo_en, CaptureDR, ShiftDR, UpdateDR,
    output sel_idr, sel_byp, ir, tap_state
  );

  modport slave (
    output TMS, TDI, idr_tdo, byp_tdo,
    input  TDO, tdo_en, CaptureDR, ShiftDR, UpdateDR,
    input  sel_idr, sel_byp, ir, tap_state
  );

endinterface

// File: rtl/tap_fsm.sv
// 16-state 1149.1 TAP state machine; one TMS-driven transition per TCK edge.
module tap_fsm
  import tap_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_t state_q
);

  tap_state_t state_d;

  // State register; synchronous reset to TLR overrides TMS.
  always_ff @(posedge tck) begin
    if (trst) begin
      state_q <= TLR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; unlisted TMS values hold the current state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:      if (!tms) state_d = RTI;
      RTI:      if (tms)  state_d = SEL_DR;
      SEL_DR:   state_d = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   state_d = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: if (tms)  state_d = EXIT1_DR;
      EXIT1_DR: state_d = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: if (tms)  state_d = EXIT2_DR;
      EXIT2_DR: state_d = tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   state_d = tms ? SEL_DR   : RTI;
      SEL_IR:   state_d = tms ? TLR      : CAP_IR;
      CAP_IR:   state_d = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: if (tms)  state_d = EXIT1_IR;
      EXIT1_IR: state_d = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: if (tms)  state_d = EXIT2_IR;
      EXIT2_IR: state_d = tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   state_d = tms ? SEL_DR   : RTI;
      default:  state_d = TLR;
    endcase
  end

endmodule

// File: rtl/tap_ctrl.sv
// TAP controller: state machine, instruction register, DR select decode and TDO mux.
module tap_ctrl
  import tap_pkg::*;
#(
  parameter int unsigned    IR_W      = TAP_IR_W,
  parameter logic [IR_W-1:0] IDCODE_OP = IR_W'(TAP_IDCODE_OP),
  parameter logic [IR_W-1:0] BYPASS_OP = IR_W'(TAP_BYPASS_OP)
) (
  input  logic  TCK,
  input  logic  TRST,
  tap_if.master bus
);

  tap_state_t      state_q;
  logic [IR_W-1:0] ir_sr_q, ir_sr_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic            sel_idr;
  logic            is_bypass_op;

  tap_fsm u_fsm (
    .tck     (TCK),
    .trst    (TRST),
    .tms     (bus.TMS),
    .state_q (state_q)
  );

  // IR shift register: capture fixed pattern, shift LSB-first toward TDO.
  always_comb begin
    ir_sr_d = ir_sr_q;
    case (state_q)
      CAP_IR:   ir_sr_d = IR_W'(TAP_IR_CAPTURE);
      SHIFT_IR: ir_sr_d = {bus.TDI, ir_sr_q[IR_W-1:1]};
      default:  ir_sr_d = ir_sr_q;
    endcase
  end

  // Instruction latch: IDCODE while in TLR, shifted value on the edge leaving UPD_IR.
  always_comb begin
    ir_d = ir_q;
    if (state_q == TLR) begin
      ir_d = IDCODE_OP;
    end else if (state_q == UPD_IR) begin
      ir_d = ir_sr_q;
    end
  end

  // IR registers; reset discards any partial scan.
  always_ff @(posedge TCK) begin
    if (TRST) begin
      ir_sr_q <= '0;
      ir_q    <= IDCODE_OP;
    end else begin
      ir_sr_q <= ir_sr_d;
      ir_q    <= ir_d;
    end
  end

  // Instruction decode: anything other than IDCODE falls back to bypass.
  assign sel_idr      = (ir_q == IDCODE_OP);
  assign is_bypass_op = (ir_q == BYPASS_OP);

  assign bus.sel_idr   = sel_idr;
  assign bus.sel_byp   = is_bypass_op | ~sel_idr;
  assign bus.ir        = ir_q;
  assign bus.tap_state = 4'(state_q);

  // Moore strobes decoded from the current state only.
  assign bus.CaptureDR = (state_q == CAP_DR);
  assign bus.ShiftDR   = (state_q == SHIFT_DR);
  assign bus.UpdateDR  = (state_q == UPD_DR);
  assign bus.tdo_en    = (state_q == SHIFT_DR) || (state_q == SHIFT_IR);

  // TDO mux; driven low outside the shift states.
  always_comb begin
    bus.TDO = 1'b0;
    case (state_q)
      SHIFT_IR: bus.TDO = ir_sr_q[0];
      SHIFT_DR: bus.TDO = sel_idr ? bus.idr_tdo : bus.byp_tdo;
      default:  bus.TDO = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_tap_ctrl.sv
// Directed-vector bench for tap_ctrl: reset, IDCODE scan, IR loads, bypass, TLR recovery.
module tb_tap_ctrl;
  import tap_pkg::*;

  localparam int unsigned IR_W = 4;

  logic TCK;
  logic TRST;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  tap_if #(.IR_W(IR_W)) bus ();

  tap_ctrl #(
    .IR_W      (IR_W),
    .IDCODE_OP (4'b0001),
    .BYPASS_OP (4'b1111)
  ) dut (
    .TCK  (TCK),
    .TRST (TRST),
    .bus  (bus.master)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag, input tap_state_t exp);
    check(tag, 32'(bus.tap_state), 32'(exp));
  endtask

  // One TCK edge with the given TMS; outputs are sampled 1 ns later.
  task automatic step(input logic tms);
    bus.TMS = tms;
    @(posedge TCK);
    #1;
  endtask

  task automatic trst_edge(input logic tms);
    TRST    = 1'b1;
    bus.TMS = tms;
    @(posedge TCK);
    #1;
    TRST = 1'b0;
  endtask

  // Scan an IR value LSB-first from RTI, ending in RTI via UPD_IR.
  task automatic load_ir(input logic [IR_W-1:0] val);
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    for (int k = 0; k < int'(IR_W); k++) begin
      bus.TDI = val[k];
      step(k == int'(IR_W) - 1);
    end
    step(1'b1);
    step(1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] id_word;
    logic [3:0]  cap_bits;
    logic [2:0]  byp_bits;
    id_word  = 32'h10001003;
    cap_bits = 4'b0001;
    byp_bits = 3'b101;

    TRST        = 1'b1;
    bus.TMS     = 1'b1;
    bus.TDI     = 1'b0;
    bus.idr_tdo = 1'b0;
    bus.byp_tdo = 1'b0;
    repeat (2) @(posedge TCK);
    #1;
    TRST = 1'b0;

    // Reset values
    check_state("rst_state", TLR);
    check("rst_ir",      32'(bus.ir),        32'h1);
    check("rst_sel_idr", 32'(bus.sel_idr),   32'h1);
    check("rst_sel_byp", 32'(bus.sel_byp),   32'h0);
    check("rst_tdo_en",  32'(bus.tdo_en),    32'h0);
    check("rst_tdo",     32'(bus.TDO),       32'h0);
    check("rst_cap",     32'(bus.CaptureDR), 32'h0);
    check("rst_shift",   32'(bus.ShiftDR),   32'h0);
    check("rst_upd",     32'(bus.UpdateDR),  32'h0);

    // TLR holds on TMS=1
    step(1'b1);
    check_state("tlr_hold", TLR);

    // IDCODE DR scan
    step(1'b0);
    check_state("rti", RTI);
    step(1'b0);
    check_state("rti_hold", RTI);
    step(1'b1);
    step(1'b0);
    check_state("cap_dr", CAP_DR);
    check("cap_strobe", 32'(bus.CaptureDR), 32'h1);
    check("cap_noshift", 32'(bus.ShiftDR), 32'h0);
    check("cap_tdo_en", 32'(bus.tdo_en), 32'h0);
    step(1'b0);
    check("cap_one_cycle", 32'(bus.CaptureDR), 32'h0);
    check("shift_dr_en", 32'(bus.ShiftDR), 32'h1);
    check("shift_dr_tdo_en", 32'(bus.tdo_en), 32'h1);
    for (int i = 0; i < 32; i++) begin
      bus.idr_tdo = id_word[i];
      bus.byp_tdo = ~id_word[i];
      #1;
      check($sformatf("idcode_bit%0d", i), 32'(bus.TDO), 32'(id_word[i]));
      step(i == 31);
    end
    check_state("exit1_dr", EXIT1_DR);
    check("exit1_noshift", 32'(bus.ShiftDR), 32'h0);
    step(1'b1);
    check("upd_strobe", 32'(bus.UpdateDR), 32'h1);
    step(1'b0);
    check("upd_one_cycle", 32'(bus.UpdateDR), 32'h0);
    check_state("upd_to_rti", RTI);

    // IR scan: captured pattern comes out 1,0,0,0 while 1111 goes in
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    check_state("shift_ir", SHIFT_IR);
    check("shift_ir_tdo_en", 32'(bus.tdo_en), 32'h1);
    for (int k = 0; k < 4; k++) begin
      bus.TDI = 1'b1;
      #1;
      check($sformatf("ir_cap_bit%0d", k), 32'(bus.TDO), 32'(cap_bits[k]));
      step(k == 3);
    end
    check_state("exit1_ir", EXIT1_IR);
    step(1'b1);
    check_state("upd_ir", UPD_IR);
    check("ir_before_leave", 32'(bus.ir), 32'h1);
    step(1'b1);
    check("ir_bypass", 32'(bus.ir), 32'hF);
    check("byp_sel_byp", 32'(bus.sel_byp), 32'h1);
    check("byp_sel_idr", 32'(bus.sel_idr), 32'h0);

    // Bypass DR scan: TDO follows byp_tdo, not idr_tdo
    step(1'b0); step(1'b0);
    for (int k = 0; k < 3; k++) begin
      bus.byp_tdo = byp_bits[k];
      bus.idr_tdo = ~byp_bits[k];
      #1;
      check($sformatf("byp_bit%0d", k), 32'(bus.TDO), 32'(byp_bits[k]));
      step(k == 2);
    end
    step(1'b0);
    step(1'b0);
    check_state("pause_dr_hold", PAUSE_DR);
    bus.byp_tdo = 1'b1;
    #1;
    check("pause_tdo", 32'(bus.TDO), 32'h0);
    check("pause_tdo_en", 32'(bus.tdo_en), 32'h0);

    // Five TMS=1 from PAUSE_DR reach TLR; IR returns to IDCODE there
    repeat (5) step(1'b1);
    check_state("pause_5x_tlr", TLR);
    step(1'b1);
    check("tlr_ir", 32'(bus.ir), 32'h1);
    check("tlr_sel_idr", 32'(bus.sel_idr), 32'h1);

    // Unknown opcode selects bypass
    step(1'b0);
    load_ir(4'b0011);
    check_state("ld3_rti", RTI);
    check("ld3_ir", 32'(bus.ir), 32'h3);
    check("ld3_sel_byp", 32'(bus.sel_byp), 32'h1);
    check("ld3_sel_idr", 32'(bus.sel_idr), 32'h0);

    // TRST from SHIFT_DR beats TMS=0
    step(1'b1); step(1'b0); step(1'b0);
    check_state("shift_dr2", SHIFT_DR);
    trst_edge(1'b0);
    check_state("trst_dr_state", TLR);
    check("trst_dr_ir", 32'(bus.ir), 32'h1);
    check("trst_dr_sel_idr", 32'(bus.sel_idr), 32'h1);
    check("trst_dr_sel_byp", 32'(bus.sel_byp), 32'h0);
    check("trst_dr_tdo_en", 32'(bus.tdo_en), 32'h0);
    check("trst_dr_shift", 32'(bus.ShiftDR), 32'h0);

    // TRST after two SHIFT_IR edges abandons the IR scan
    step(1'b0);
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    bus.TDI = 1'b1;
    step(1'b0); step(1'b0);
    check_state("shift_ir_partial", SHIFT_IR);
    trst_edge(1'b1);
    check_state("trst_ir_state", TLR);
    check("trst_ir_ir", 32'(bus.ir), 32'h1);
    check("trst_ir_sel_idr", 32'(bus.sel_idr), 32'h1);
    check("trst_ir_tdo_en", 32'(bus.tdo_en), 32'h0);
    step(1'b1);
    check("trst_ir_no_upd", 32'(bus.ir), 32'h1);

    // Four TMS=1 from SHIFT_IR is not enough for TLR; the fifth is
    step(1'b0);
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    repeat (4) step(1'b1);
    check_state("shift_ir_4x", SEL_IR);
    step(1'b1);
    check_state("shift_ir_5x", TLR);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tap_ctrl.md
TAP_CTRL -- requirements
Module: tap_ctrl

Interface
REQ-001 Parameter IR_W, default 4, instruction register width in bits.
REQ-002 Parameter IDCODE_OP, default 4'b0001, opcode selecting the ID register.
REQ-003 Parameter BYPASS_OP, default 4'b1111, opcode selecting the bypass register.
REQ-004 TCK  in  1  the only clock; all state changes on the rising edge.
REQ-005 TRST  in  1  reset, synchronous, active-high.
REQ-006 TMS  in  1  test mode select; sampled on the rising edge of TCK.
REQ-007 TDI  in  1  serial data in; sampled on the rising edge of TCK.
REQ-008 idr_tdo  in  1  serial output bit (LSB) of the ID register.
REQ-009 byp_tdo  in  1  serial output bit of the bypass register.
REQ-010 TDO  out  1  serial data out.
REQ-011 tdo_en  out  1  TDO valid; high only in SHIFT_IR or SHIFT_DR.
REQ-012 CaptureDR  out  1  DR capture strobe.
REQ-013 ShiftDR  out  1  DR shift enable.
REQ-014 UpdateDR  out  1  DR update strobe.
REQ-015 sel_idr  out  1  ID register is the selected DR.
REQ-016 sel_byp  out  1  bypass register is the selected DR.
REQ-017 ir  out  IR_W  current (updated) instruction.
REQ-018 tap_state  out  4  current TAP state encoding, for debug.

Function
REQ-019 16-state IEEE 1149.1 FSM, one transition per TCK edge on TMS.
- TLR: 0->RTI.
- RTI: 1->SEL_DR.
- SEL_DR: 0->CAP_DR, 1->SEL_IR.
- SEL_IR: 0->CAP_IR, 1->TLR.
- CAP_x: 0->SHIFT_x, 1->EXIT1_x.
- SHIFT_x: 1->EXIT1_x.
- EXIT1_x: 0->PAUSE_x, 1->UPD_x.
- PAUSE_x: 1->EXIT2_x.
- EXIT2_x: 0->SHIFT_x, 1->UPD_x.
- UPD_x: 0->RTI, 1->SEL_DR.
- Any transition not listed holds the current state.
REQ-020 Five consecutive TMS=1 edges from any state SHALL reach TLR.
REQ-021 Output decode is Moore, from the current state only.
- CaptureDR=1 only in CAP_DR.
- ShiftDR=1 only in SHIFT_DR.
- UpdateDR=1 only in UPD_DR.
- Each strobe is exactly one TCK wide per state visit.
REQ-022 IR shift register ir_sr is IR_W bits wide.
- CAP_IR: ir_sr <= {{IR_W-2{0}},2'b01}.
- SHIFT_IR: ir_sr <= {TDI, ir_sr[IR_W-1:1]}; LSB leaves first.
REQ-023 ir loads ir_sr on the edge leaving UPD_IR, and loads IDCODE_OP whenever the state is TLR; it holds otherwise.
REQ-024 Instruction decode:
- sel_idr = (ir==IDCODE_OP).
- sel_byp = !sel_idr; this covers BYPASS_OP and every unknown opcode.
REQ-025 TDO mux:
- SHIFT_IR: TDO = ir_sr[0].
- SHIFT_DR: TDO = sel_idr ? idr_tdo : byp_tdo.
- All other states: TDO = 0.
- TDO is combinational from registered state and registers.
REQ-026 An IR change mid-DR-scan is structurally impossible; the design relies on no other guard.

Reset
REQ-027 TRST=1 at an edge SHALL force:
- state=TLR, ir=IDCODE_OP, ir_sr=0;
- TDO=0, tdo_en=0, all strobes 0;
- sel_idr=1, sel_byp=0.
REQ-028 TRST takes priority over TMS; a scan in progress is abandoned and partial ir_sr contents are discarded.

Structure
REQ-029 Shared package tap_pkg holds:
- the tap_state_t enum (4-bit, 16 states);
- IDCODE_OP and BYPASS_OP constants;
- IR capture pattern constant.
REQ-030 One sub-module, tap_fsm, holds the state register and next-state logic.
- tap_ctrl holds the IR, the decode and the TDO mux.

Verification
REQ-031 TRST=1 for one edge from SHIFT_DR -> tap_state=TLR, ir=0001, sel_idr=1, tdo_en=0.
REQ-032 From TLR, TMS=0,1,0,0 -> CaptureDR high one cycle, then ShiftDR=1.
- Then 32 edges with idr_tdo=0x10001003 LSB-first -> TDO matches idr_tdo each cycle.
REQ-033 From RTI, TMS=1,1,0,0 -> SHIFT_IR; TDO bits 1,0,0,0.
- Shift TDI=1,1,1,1 with TMS=1 on the 4th bit, then TMS=1 -> ir=1111, sel_byp=1, TDO follows byp_tdo in SHIFT_DR.
REQ-034 Load ir=0011 -> sel_byp=1, sel_idr=0.
REQ-035 From PAUSE_DR, TMS=1 for five edges -> TLR, ir=0001; from SHIFT_IR, fewer than five -> not TLR.
REQ-036 TRST=1 after two SHIFT_IR edges -> next state TLR, ir=0001, no UpdateIR effect.
